// File: rtl/tucanos_pkg.sv
// Shared definitions for the tucanos context switcher: FSM states,
// watchdog code values, default OS entry address and index helpers.
package tucanos_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAVE     = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_OS_RUN   = 3'd3,
      ST_DISPATCH = 3'd4
   } state_t;

   // Watchdog codes carried on state_register
   localparam logic [31:0] INDEX_ONE   = 32'd1;
   localparam logic [31:0] INDEX_TWO   = 32'd2;
   localparam logic [31:0] INDEX_THREE = 32'd3;
   localparam logic [31:0] WAIT_ENABLE = 32'd4;
   localparam logic [31:0] HALT_ENABLE = 32'd5;

   localparam logic [11:0] OS_ENTRY_ADDR_DEFAULT = 12'd256;

   // Process index 1..3 maps to mask bit 0..2; index 0 (no process) maps to nothing
   function automatic logic [2:0] index_to_mask(input logic [1:0] idx);
      case (idx)
         2'd1:    return 3'b001;
         2'd2:    return 3'b010;
         2'd3:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/tucanos_pc_table.sv
// Saved program counters of user processes 1..3.
// One synchronous write port, one combinational read port; index 0 is not a
// process, so writes to it are dropped and reads of it return zero.
module tucanos_pc_table #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  write_en,
   input  logic [1:0]            write_index,
   input  logic [ADDR_WIDTH-1:0] write_data,
   input  logic [1:0]            read_index,
   output logic [ADDR_WIDTH-1:0] read_data
);

   logic [ADDR_WIDTH-1:0] entry_r [3];

   // Table storage: cleared on reset, one entry written per enabled cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            entry_r[i] <= '0;
         end
      end else if (write_en) begin
         case (write_index)
            2'd1:    entry_r[0] <= write_data;
            2'd2:    entry_r[1] <= write_data;
            2'd3:    entry_r[2] <= write_data;
            default: ;
         endcase
      end
   end

   // Combinational read of the addressed entry
   always_comb begin
      read_data = '0;
      case (read_index)
         2'd1:    read_data = entry_r[0];
         2'd2:    read_data = entry_r[1];
         2'd3:    read_data = entry_r[2];
         default: read_data = '0;
      endcase
   end

endmodule

// File: rtl/tucanos_context_switcher.sv
// Context switcher between watchdog, user processes and the OS.
// A watchdog request saves the running PC, records wait/halt/next-process
// information and jumps to the OS; an OS resume strobe dispatches a process
// from its saved PC.
// Optional feature: define CONTEXT_SWITCH_COUNT_EN to add the saturating
// 16-bit switch_count output counting dispatches.
module tucanos_context_switcher
   import tucanos_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = 12,
   parameter int                    DATA_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] OS_ENTRY_ADDR = ADDR_WIDTH'(OS_ENTRY_ADDR_DEFAULT)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  jump_enabler,
   input  logic [DATA_WIDTH-1:0] state_register,
   input  logic [ADDR_WIDTH-1:0] program_counter,
   input  logic                  os_resume,
   input  logic [1:0]            resume_index,
   output logic                  jump_request,
   output logic [ADDR_WIDTH-1:0] jump_address,
   output logic [1:0]            current_index,
   output logic [1:0]            next_index,
   output logic [2:0]            waiting_mask,
   output logic [2:0]            halted_mask,
   output logic                  busy,
   output logic                  resume_error
`ifdef CONTEXT_SWITCH_COUNT_EN
   ,
   output logic [15:0]           switch_count
`endif
);

   state_t                state_r;
   state_t                state_next_s;
   logic                  jump_prev_r;
   logic [DATA_WIDTH-1:0] code_r;
   logic [1:0]            dispatch_index_r;
   logic [ADDR_WIDTH-1:0] table_read_s;

   logic rise_s;
   logic capture_s;
   logic save_s;
   logic redirect_s;
   logic dispatch_s;
   logic resume_ok_s;
   logic resume_bad_s;

   assign rise_s = jump_enabler & ~jump_prev_r;

   tucanos_pc_table #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_table (
      .clock       (clock),
      .reset_n     (reset_n),
      .write_en    (save_s),
      .write_index (current_index),
      .write_data  (program_counter),
      .read_index  (dispatch_index_r),
      .read_data   (table_read_s)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and per-state action strobes
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      save_s       = 1'b0;
      redirect_s   = 1'b0;
      dispatch_s   = 1'b0;
      resume_ok_s  = 1'b0;
      resume_bad_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rise_s) begin
               capture_s    = 1'b1;
               state_next_s = ST_SAVE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SAVE: begin
            save_s       = 1'b1;
            state_next_s = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_s   = 1'b1;
            state_next_s = ST_OS_RUN;
         end
         ST_OS_RUN: begin
            // jump_enabler is deliberately not looked at while the OS runs
            if (os_resume) begin
               if ((resume_index != 2'd0) &&
                   ((index_to_mask(resume_index) & halted_mask) == 3'b000)) begin
                  resume_ok_s  = 1'b1;
                  state_next_s = ST_DISPATCH;
               end else begin
                  resume_bad_s = 1'b1;
                  state_next_s = ST_OS_RUN;
               end
            end else begin
               state_next_s = ST_OS_RUN;
            end
         end
         ST_DISPATCH: begin
            dispatch_s   = 1'b1;
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Edge history, captured code and the index chosen by the OS
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         jump_prev_r      <= 1'b0;
         code_r           <= '0;
         dispatch_index_r <= 2'd0;
      end else begin
         jump_prev_r <= jump_enabler;
         if (capture_s) begin
            code_r <= state_register;
         end
         if (resume_ok_s) begin
            dispatch_index_r <= resume_index;
         end
      end
   end

   // Registered jump strobe, target, status and error outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         jump_request <= 1'b0;
         jump_address <= '0;
         busy         <= 1'b0;
         resume_error <= 1'b0;
      end else begin
         jump_request <= redirect_s | dispatch_s;
         busy         <= (state_next_s != ST_IDLE);
         resume_error <= resume_bad_s;
         // Target holds between strobes
         if (redirect_s) begin
            jump_address <= OS_ENTRY_ADDR;
         end else if (dispatch_s) begin
            jump_address <= table_read_s;
         end
      end
   end

   // Process bookkeeping: running/proposed index and wait/halt masks
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         current_index <= 2'd0;
         next_index    <= 2'd0;
         waiting_mask  <= 3'b000;
         halted_mask   <= 3'b000;
      end else if (save_s) begin
         if ((code_r == DATA_WIDTH'(INDEX_ONE)) ||
             (code_r == DATA_WIDTH'(INDEX_TWO)) ||
             (code_r == DATA_WIDTH'(INDEX_THREE))) begin
            next_index <= code_r[1:0];
         end else if (code_r == DATA_WIDTH'(WAIT_ENABLE)) begin
            waiting_mask <= waiting_mask | index_to_mask(current_index);
         end else if (code_r == DATA_WIDTH'(HALT_ENABLE)) begin
            halted_mask <= halted_mask | index_to_mask(current_index);
         end
      end else if (dispatch_s) begin
         current_index <= dispatch_index_r;
         waiting_mask  <= waiting_mask & ~index_to_mask(dispatch_index_r);
      end
   end

`ifdef CONTEXT_SWITCH_COUNT_EN
   // Saturating count of dispatches
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         switch_count <= 16'd0;
      end else if (dispatch_s && (switch_count != 16'hFFFF)) begin
         switch_count <= switch_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/tucanos_context_switcher.md
TUCANOS_CONTEXT_SWITCHER -- requirements
Module: tucanos_context_switcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, program counter / jump address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the watchdog state code.
REQ-003 SHALL have parameter OS_ENTRY_ADDR, default 12'd256, operating system entry address.
REQ-004 SHALL have ports: clock in 1, system clock; reset_n in 1, reset. The block uses one clock; reset_n is asynchronous and active-low.
REQ-005 SHALL have port jump_enabler in 1, watchdog request for an OS jump (WAIT/HALT/CHANGE).
REQ-006 SHALL have port state_register in DATA_WIDTH, watchdog code: 1..3 next process index, 4 wait, 5 halt.
REQ-007 SHALL have port program_counter in ADDR_WIDTH, PC of the running user process.
REQ-008 SHALL have ports os_resume in 1, OS dispatch strobe; resume_index in 2, process to dispatch.
REQ-009 SHALL have outputs: jump_request 1, one-cycle jump strobe; jump_address ADDR_WIDTH, target; current_index 2, running process; next_index 2, watchdog-proposed process; waiting_mask 3; halted_mask 3; busy 1; resume_error 1.

Function
REQ-010 SHALL update all state on posedge clock.
REQ-011 SHALL keep a 3-entry PC table (processes 1..3), ADDR_WIDTH per entry.
REQ-012 SHALL implement FSM IDLE, SAVE, REDIRECT, OS_RUN, DISPATCH.
REQ-013 IDLE: on a jump_enabler rising edge (registered previous value), latch state_register into a code register and go to SAVE; a held-high jump_enabler SHALL cause one capture only.
REQ-014 SAVE: write program_counter into the table entry of current_index (skipped if current_index==0); code 1..3 -> next_index <= code[1:0]; code 4 -> set waiting_mask bit of current_index; code 5 -> set halted_mask bit of current_index; any other code -> table write only; go to REDIRECT.
REQ-015 REDIRECT: assert jump_request for exactly one cycle with jump_address=OS_ENTRY_ADDR; go to OS_RUN.
REQ-016 OS_RUN: ignore jump_enabler; on os_resume with resume_index in 1..3 and halted bit clear, latch index and go to DISPATCH.
REQ-017 OS_RUN: os_resume with resume_index 0 or a halted process SHALL pulse resume_error for one cycle and stay in OS_RUN.
REQ-018 DISPATCH: jump_request=1 for one cycle, jump_address=table[index], current_index<=index, clear that waiting_mask bit; go to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 jump_address SHALL hold its last value when jump_request is 0.
REQ-021 os_resume in IDLE, SAVE, REDIRECT or DISPATCH SHALL be ignored with no resume_error.
REQ-022 Latency: jump_enabler rise at edge N -> jump_request at edge N+2 (SAVE at N, REDIRECT at N+1); os_resume at edge M -> jump_request at M+1.

Reset
REQ-023 reset_n low SHALL asynchronously force IDLE, all outputs 0, PC table 0, code register 0, jump_enabler history 0.
REQ-024 Reset asserted mid-operation SHALL abort the switch; a jump_enabler already high at release SHALL be captured as a rising edge.

Configuration
REQ-025 With CONTEXT_SWITCH_COUNT_EN defined, SHALL add output switch_count 16 bits, incremented on each DISPATCH and saturating at 16'hFFFF, reset to 0.
REQ-026 Without CONTEXT_SWITCH_COUNT_EN, SHALL have no switch_count port or counter.

Structure
REQ-027 The shared package tucanos_pkg SHALL hold the FSM state enum, watchdog code constants (INDEX_ONE..INDEX_THREE, WAIT_ENABLE=4, HALT_ENABLE=5) and OS_ENTRY_ADDR default.
REQ-028 The PC table SHALL be a sub-module tucanos_pc_table (3 entries, one write port, one combinational read port).

Verification
REQ-029 Reset; current_index=1 via dispatch; PC=12'h012, jump_enabler rises with code 2 -> table[1]=12'h012, next_index=2, jump_request one cycle at OS_ENTRY_ADDR 256.
REQ-030 In OS_RUN, os_resume index 1 -> next cycle jump_request=1, jump_address=12'h012, current_index=1, busy=0 after.
REQ-031 Code 5 while current_index=3 -> halted_mask=3'b100; later os_resume index 3 -> resume_error pulse, no jump_request.
REQ-032 Code 4 on process 2 -> waiting_mask=3'b010; os_resume index 2 -> bit cleared on dispatch.
REQ-033 jump_enabler held high 5 cycles -> exactly one jump_request to 256; second rise during OS_RUN ignored.
REQ-034 reset_n pulsed low in OS_RUN -> IDLE, all masks 0, switch_count 0 (macro defined), no jump_request.
